// File: rtl/buck_ctrl_pkg.sv
// buck_ctrl_pkg: shared FSM state encoding for the buck PWM controller.
package buck_ctrl_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE       = 2'd0,
    SOFT_START = 2'd1,
    RUN        = 2'd2,
    FAULT      = 2'd3
  } state_t;
endpackage

// File: rtl/pwm_period_cnt.sv
// pwm_period_cnt: free-running 0..PERIOD_CYCLES-1 period counter with registered wrap pulse.
module pwm_period_cnt #(
  parameter int PERIOD_CYCLES = 200,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             wrap,
  output logic             period_start
);
  assign wrap    = cnt == CNT_W'(PERIOD_CYCLES - 1);
  assign cnt_nxt = (clr || wrap) ? '0 : cnt + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      period_start <= wrap && !clr;
    end
endmodule

// File: rtl/buck_pwm_ctrl.sv
// buck_pwm_ctrl: buck converter PWM with soft-start, overcurrent fault and holdoff.
// Define BUCK_PWM_CTRL_AUTORETRY_EN to restart soft-start after holdoff instead of latching FAULT.
module buck_pwm_ctrl import buck_ctrl_pkg::*; #(
  parameter int PERIOD_CYCLES   = 200,
  parameter int CNT_W           = 16,
  parameter int SS_STEP         = 4,
  parameter int HOLDOFF_PERIODS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [CNT_W-1:0]   duty_cmd,
  input  logic               oc,
  output logic               gate,
  output logic               period_start,
  output logic [STATE_W-1:0] state
);
  localparam int HW = $clog2(HOLDOFF_PERIODS + 1);
  localparam logic [CNT_W-1:0] PMAX = CNT_W'(PERIOD_CYCLES);
  state_t st;
  logic [CNT_W-1:0] cnt, cnt_nxt, duty_act, target, ss_duty, nxt_duty;
  logic [CNT_W:0] ss_sum;
  logic [HW-1:0] hold;
  logic wrap;
  // Counter is cleared while idle and on the edge that returns to idle.
  pwm_period_cnt #(.PERIOD_CYCLES(PERIOD_CYCLES), .CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .clr(st == IDLE || !en),
    .cnt(cnt), .cnt_nxt(cnt_nxt), .wrap(wrap), .period_start(period_start)
  );
  always_comb begin
    target   = (duty_cmd >= PMAX) ? PMAX : duty_cmd;
    ss_sum   = {1'b0, duty_act} + (CNT_W+1)'(SS_STEP);
    ss_duty  = (ss_sum >= {1'b0, target}) ? target : ss_sum[CNT_W-1:0];
    nxt_duty = (st == SOFT_START) ? ss_duty : target;
  end
  assign state = st;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st       <= IDLE;
      duty_act <= '0;
      hold     <= '0;
      gate     <= 1'b0;
    end else if (st == IDLE) begin
      st       <= (en && !oc) ? SOFT_START : IDLE;
      duty_act <= '0;
      hold     <= '0;
      gate     <= 1'b0;
    end else if (!en) begin
      st       <= IDLE;
      duty_act <= '0;
      hold     <= '0;
      gate     <= 1'b0;
    end else if (st == FAULT) begin
      gate <= 1'b0;
      if (oc) hold <= '0;
      else if (wrap) begin
`ifdef BUCK_PWM_CTRL_AUTORETRY_EN
        if (hold == HW'(HOLDOFF_PERIODS - 1)) begin
          st       <= SOFT_START;
          duty_act <= '0;
          hold     <= '0;
        end else hold <= hold + 1'b1;
`else
        if (hold != HW'(HOLDOFF_PERIODS)) hold <= hold + 1'b1;
`endif
      end
    end else if (oc) begin
      st   <= FAULT;
      hold <= '0;
      gate <= 1'b0;
    end else if (wrap) begin
      duty_act <= nxt_duty;
      gate     <= |nxt_duty;
      if (st == SOFT_START && nxt_duty == target) st <= RUN;
    end else gate <= cnt_nxt < duty_act;
endmodule

// File: tb/tb_buck_pwm_ctrl.sv
// tb_buck_pwm_ctrl: directed and randomized checks of buck_pwm_ctrl against a period-level model.
module tb_buck_pwm_ctrl;
  localparam int P = 10, S = 2, H = 4;
`ifdef BUCK_PWM_CTRL_AUTORETRY_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, oc = 1'b0;
  logic [15:0] duty_cmd = '0;
  logic gate, period_start;
  logic [1:0] state;
  int n_cmp = 0, n_bad = 0;
  int m_st, m_cnt, m_duty, m_hold, hi;
  bit e_gate, e_ps;

  buck_pwm_ctrl #(.PERIOD_CYCLES(P), .CNT_W(16), .SS_STEP(S), .HOLDOFF_PERIODS(H)) dut (
    .clk(clk), .rst(rst), .en(en), .duty_cmd(duty_cmd), .oc(oc),
    .gate(gate), .period_start(period_start), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_cnt = 0; m_duty = 0; m_hold = 0; e_gate = 0; e_ps = 0;
  endtask

  // Model: mode 0..3, position within period, on-time for this period, wraps seen in fault.
  task automatic step();
    bit wr;
    int tgt;
    if (rst) begin m_reset(); return; end
    tgt = (duty_cmd >= 16'(P)) ? P : int'(duty_cmd);
    wr = (m_cnt == P - 1);
    e_ps = 0;
    if (m_st == 0) begin
      if (en && !oc) m_st = 1;
      m_duty = 0; m_cnt = 0;
    end else if (!en) begin
      m_st = 0; m_cnt = 0; m_duty = 0;
    end else begin
      e_ps = wr;
      m_cnt = wr ? 0 : m_cnt + 1;
      if (m_st == 3) begin
        if (oc) m_hold = 0;
        else if (wr) begin
          m_hold++;
          if (AR && m_hold == H) begin m_st = 1; m_duty = 0; m_hold = 0; end
        end
      end else if (oc) begin
        m_st = 3; m_hold = 0;
      end else if (wr) begin
        m_duty = (m_st == 2) ? tgt : ((m_duty + S < tgt) ? m_duty + S : tgt);
        if (m_st == 1 && m_duty == tgt) m_st = 2;
      end
    end
    e_gate = (m_st == 1 || m_st == 2) && m_cnt < m_duty;
  endtask

  task automatic cyc();
    @(posedge clk);
    step();
    #1;
    chk("gate", 32'(gate), 32'(e_gate));
    chk("period_start", 32'(period_start), 32'(e_ps));
    chk("state", 32'(state), 32'(m_st));
  endtask

  task automatic wait_for(input int st, input int c);
    int k = 0;
    while (!(m_st == st && m_cnt == c) && k < 300) begin cyc(); k++; end
    if (!(m_st == st && m_cnt == c)) begin
      n_cmp++; n_bad++;
      $error("FAIL wait: state %0d cnt %0d not reached within %0d cycles", st, c, k);
    end
  endtask

  task automatic count_period(input string tag, input int exp);
    hi = 0;
    repeat (P) begin cyc(); hi += int'(gate); end
    chk(tag, 32'(hi), 32'(exp));
  endtask

  initial begin
    m_reset();
    #12;
    chk("reset_gate", 32'(gate), 0);
    chk("reset_state", 32'(state), 0);
    chk("reset_ps", 32'(period_start), 0);
    rst = 0;
    // Soft-start ramp 2,4,6 then steady 6/10
    duty_cmd = 16'd6; en = 1;
    cyc();
    chk("ss_entry_state", 32'(state), 1);
    repeat (P - 1) cyc();
    count_period("ss_p1_high", 2);
    chk("ss_p1_state", 32'(state), 1);
    count_period("ss_p2_high", 4);
    count_period("ss_p3_high", 6);
    chk("run_state", 32'(state), 2);
    count_period("run_p4_high", 6);
    // Lowered duty mid-period applies at next period
    hi = 0;
    repeat (3) begin cyc(); hi += int'(gate); end
    duty_cmd = 16'd3;
    repeat (P - 3) begin cyc(); hi += int'(gate); end
    chk("duty_drop_cur", 32'(hi), 6);
    count_period("duty_drop_next", 3);
    duty_cmd = 16'd15;
    count_period("duty_full", P);
    duty_cmd = 16'd0;
    count_period("duty_zero", 0);
    // Overcurrent at cnt=3
    duty_cmd = 16'd6;
    count_period("pre_oc_high", 6);
    repeat (4) cyc();
    oc = 1;
    cyc();
    oc = 0;
    chk("oc_gate", 32'(gate), 0);
    chk("oc_state", 32'(state), 3);
    repeat (35) cyc();
    chk("holdoff_state", 32'(state), 3);
    cyc();
    chk("holdoff_exit", 32'(state), AR ? 1 : 3);
    hi = int'(gate);
    repeat (P - 1) begin cyc(); hi += int'(gate); end
    chk("retry_p0_high", 32'(hi), 0);
    count_period("retry_p1_high", AR ? 2 : 0);
    en = 0;
    cyc();
    chk("fault_en_off", 32'(state), 0);
    // Async reset mid-period in RUN
    en = 1;
    wait_for(2, 4);
    #3 rst = 1;
    #1;
    chk("async_rst_gate", 32'(gate), 0);
    chk("async_rst_state", 32'(state), 0);
    m_reset();
    rst = 0;
    cyc();
    chk("post_rst_ss", 32'(state), 1);
    // en=0 wins over oc
    wait_for(2, 5);
    en = 0; oc = 1;
    cyc();
    chk("en_over_oc", 32'(state), 0);
    oc = 0; en = 1;
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 99) < 98);
      oc = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 19) == 0) duty_cmd = 16'($urandom_range(0, 12));
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/buck_pwm_ctrl.md
BUCK_PWM_CTRL -- requirements
Module: buck_pwm_ctrl

Interface
REQ-001 Parameter PERIOD_CYCLES, default 200: clk cycles per PWM period.
REQ-002 Parameter CNT_W, default 16: width of counter, duty command and duty register.
REQ-003 Parameter SS_STEP, default 4: duty increment per period during soft-start.
REQ-004 Parameter HOLDOFF_PERIODS, default 8: whole periods spent in FAULT before exit is allowed.
REQ-005 Port clk, input, 1: sole clock.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port en, input, 1: converter enable.
REQ-008 Port duty_cmd, input, CNT_W: on-cycles per period requested.
REQ-009 Port oc, input, 1: overcurrent flag from the i_mag comparator.
REQ-010 Port gate, output, 1: registered power-switch drive.
REQ-011 Port period_start, output, 1: one-cycle pulse when the counter wraps to 0.
REQ-012 Port state, output, 2: current FSM state encoding.

Function
REQ-013 Counter cnt SHALL count 0..PERIOD_CYCLES-1 and wrap to 0; it SHALL run in every state except IDLE, where it is held at 0.
REQ-014 gate SHALL be registered and equal (cnt < duty_act) on the same edge cnt updates; it SHALL be 0 in IDLE and FAULT.
REQ-015 duty_act SHALL change only on the wrap edge (cnt 0 next), never mid-period.
REQ-016 The target SHALL be min(duty_cmd, PERIOD_CYCLES), so duty_cmd >= PERIOD_CYCLES gives 100 % duty and 0 gives 0 %.
REQ-017 FSM states SHALL be IDLE=0, SOFT_START=1, RUN=2 and FAULT=3.
REQ-018 IDLE to SOFT_START SHALL occur on en=1 with oc=0; cnt starts at 0 and duty_act starts at 0.
REQ-019 In SOFT_START, each wrap SHALL set duty_act = min(duty_act+SS_STEP, target); when the result equals target, the state becomes RUN.
REQ-020 In RUN, each wrap SHALL load duty_act = target; a lowered duty_cmd is applied directly, with no ramp-down.
REQ-021 From any non-IDLE state, en=0 SHALL force IDLE on the next edge, with gate=0 and duty_act=0.
REQ-022 oc=1 sampled in SOFT_START or RUN SHALL force FAULT on the next edge with gate=0 on that same edge, regardless of cnt.
REQ-023 FAULT SHALL count HOLDOFF_PERIODS wraps; oc=1 during holdoff SHALL restart the holdoff count.
REQ-024 When en=0 and oc=1 occur in the same cycle, en=0 SHALL take priority and the next state is IDLE.
REQ-025 period_start SHALL pulse in all non-IDLE states, including FAULT.

Reset
REQ-026 On rst=1, asynchronously: state=IDLE, cnt=0, duty_act=0, holdoff count=0, gate=0, period_start=0.
REQ-027 rst asserted mid-period SHALL drop gate immediately; after release, operation restarts from IDLE with a fresh soft-start.

Configuration
REQ-028 Macro BUCK_PWM_CTRL_AUTORETRY_EN defined: at holdoff expiry with oc=0 and en=1, the state becomes SOFT_START with duty_act=0.
REQ-029 Macro BUCK_PWM_CTRL_AUTORETRY_EN undefined: FAULT SHALL latch until en=0, which returns the block to IDLE.

Structure
REQ-030 A shared package buck_ctrl_pkg SHALL hold the state enum typedef and its 2-bit encoding.
REQ-031 The period counter and wrap pulse SHALL be one sub-module, pwm_period_cnt; the FSM, duty register and holdoff logic stay in the top.

Verification
REQ-032 PERIOD_CYCLES=10, SS_STEP=2, duty_cmd=6, en rises -> gate high 2, 4 and 6 cycles in periods 1-3; state=RUN from the 3rd wrap; steady 6/10 thereafter.
REQ-033 RUN with duty_cmd changed 6->3 at cnt=2 -> the current period stays 6 high; the next period is 3 high.
REQ-034 duty_cmd=15 with PERIOD_CYCLES=10 -> gate constantly 1 in RUN; duty_cmd=0 -> gate constantly 0.
REQ-035 oc pulse at cnt=3 in RUN, HOLDOFF_PERIODS=4 -> gate=0 on the next edge; FAULT for 4 wraps; with the macro, soft-start restarts at 2/10; without it, FAULT holds until en=0.
REQ-036 rst pulse at cnt=4 in RUN -> gate=0 asynchronously; after release, state=IDLE and a soft-start follows en.
REQ-037 en=0 and oc=1 in the same cycle -> next state IDLE, not FAULT.
